// File: rtl/mem_io_responder.sv
`default_nettype none
// ============================================================================
// Module   : mem_io_responder
// Brief    : Byte-wide CPU bus responder: 128KB RAM plus UART FIFOs, a cycle
//            counter and a stop flag mapped at 0x3xxxx. Optional macro
//            ADDR_TRAP_EN traps 0x2xxxx accesses instead of aliasing RAM.
// Revision : 1.0 - initial release
// ============================================================================
module mem_io_responder #(
    parameter int RAM_ADDR_W = 17,
    parameter int TX_DEPTH   = 16,
    parameter int RX_DEPTH   = 16
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [31:0] mem_a,
    input  logic [7:0]  mem_dout,
    input  logic        mem_wr,
    output logic [7:0]  mem_din,
    output logic        cpu_rdy,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        prog_stop,
    output logic        addr_err
);
    localparam int c_TX_AW = $clog2(TX_DEPTH);
    localparam int c_RX_AW = $clog2(RX_DEPTH);
    localparam logic [c_TX_AW:0] c_TX_FULL    = (c_TX_AW + 1)'(TX_DEPTH);
    localparam logic [c_TX_AW:0] c_TX_RDY_MAX = (c_TX_AW + 1)'(TX_DEPTH - 2);
    localparam logic [c_RX_AW:0] c_RX_FULL    = (c_RX_AW + 1)'(RX_DEPTH);

    logic [17:0]           w_addr;
    logic [RAM_ADDR_W-1:0] w_ram_idx;
    logic                  w_is_io, w_is_oor, w_oor_trap, w_ram_sel;
    logic                  w_rd_rx, w_rd_cnt, w_wr_tx, w_wr_stop;
    logic                  w_tx_push, w_tx_pop, w_rx_push, w_rx_pop;
    logic [7:0]            w_tx_wdata, w_io_d;
    logic                  w_unused;

    logic [7:0]  r_ram [2**RAM_ADDR_W];
    logic [7:0]  r_ram_q, r_io_q;
    logic        r_sel_io, r_prev_rd_rx, r_stop;
    logic [31:0] r_cnt;
    logic [31:8] r_snap_hi;

    logic [7:0]         r_tx_mem [TX_DEPTH];
    logic [c_TX_AW-1:0] r_tx_wp, r_tx_rp;
    logic [c_TX_AW:0]   r_tx_cnt;
    logic [7:0]         r_rx_mem [RX_DEPTH];
    logic [c_RX_AW-1:0] r_rx_wp, r_rx_rp;
    logic [c_RX_AW:0]   r_rx_cnt;

    assign w_addr    = mem_a[17:0];
    assign w_ram_idx = mem_a[RAM_ADDR_W-1:0];
    assign w_is_io   = (w_addr[17:16] == 2'b11);
    assign w_is_oor  = (w_addr[17:16] == 2'b10);
    assign w_unused  = ^{mem_a[31:18], w_is_oor};
`ifdef ADDR_TRAP_EN
    assign w_oor_trap = w_is_oor;
`else
    assign w_oor_trap = 1'b0;
`endif
    assign w_ram_sel = !w_is_io && !w_oor_trap;
    assign w_rd_rx   = w_is_io && !mem_wr && (w_addr[15:0] == 16'h0000);
    assign w_rd_cnt  = w_is_io && !mem_wr && (w_addr[15:2] == 14'h0001);
    assign w_wr_tx   = w_is_io && mem_wr && (w_addr[15:0] == 16'h0000) && (mem_dout != 8'h00);
    assign w_wr_stop = w_is_io && mem_wr && (w_addr[15:0] == 16'h0004);

    // One slot stays free for a write already issued when cpu_rdy drops
    assign cpu_rdy    = (r_tx_cnt <= c_TX_RDY_MAX);
    assign tx_valid   = (r_tx_cnt != '0);
    assign tx_data    = r_tx_mem[r_tx_rp];
    assign w_tx_pop   = tx_valid && tx_ready;
    assign w_tx_push  = (w_wr_tx || w_wr_stop) && (r_tx_cnt != c_TX_FULL);
    assign w_tx_wdata = w_wr_stop ? 8'h00 : mem_dout;

    assign rx_ready  = (r_rx_cnt != c_RX_FULL);
    assign w_rx_push = rx_valid && rx_ready;
    // A frozen CPU repeats its read; only the first of a run of RX reads pops
    assign w_rx_pop  = w_rd_rx && !r_prev_rd_rx && (r_rx_cnt != '0);

    always_comb begin
        w_io_d = 8'h00;
        if (w_oor_trap && !mem_wr) begin
            w_io_d = 8'hFF;
        end else if (w_rd_rx) begin
            if (r_prev_rd_rx)
                w_io_d = r_io_q;
            else if (r_rx_cnt != '0)
                w_io_d = r_rx_mem[r_rx_rp];
        end else if (w_rd_cnt) begin
            case (w_addr[1:0])
                2'd0:    w_io_d = r_cnt[7:0];
                2'd1:    w_io_d = r_snap_hi[15:8];
                2'd2:    w_io_d = r_snap_hi[23:16];
                default: w_io_d = r_snap_hi[31:24];
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (mem_wr && w_ram_sel)
            r_ram[w_ram_idx] <= mem_dout;
        r_ram_q <= r_ram[w_ram_idx];
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_sel_io     <= 1'b1;
            r_io_q       <= 8'h00;
            r_prev_rd_rx <= 1'b0;
            r_cnt        <= '0;
            r_snap_hi    <= '0;
            r_stop       <= 1'b0;
        end else begin
            r_sel_io     <= !w_ram_sel;
            r_io_q       <= w_io_d;
            r_prev_rd_rx <= w_rd_rx;
            r_cnt        <= r_cnt + 32'd1;
            if (w_rd_cnt && (w_addr[1:0] == 2'b00))
                r_snap_hi <= r_cnt[31:8];
            if (w_wr_stop)
                r_stop <= 1'b1;
        end
    end

    assign mem_din   = r_sel_io ? r_io_q : r_ram_q;
    assign prog_stop = r_stop;

    always_ff @(posedge clk_in) begin
        if (w_tx_push)
            r_tx_mem[r_tx_wp] <= w_tx_wdata;
        if (w_rx_push)
            r_rx_mem[r_rx_wp] <= rx_data;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_tx_wp  <= '0;
            r_tx_rp  <= '0;
            r_tx_cnt <= '0;
            r_rx_wp  <= '0;
            r_rx_rp  <= '0;
            r_rx_cnt <= '0;
        end else begin
            if (w_tx_push)
                r_tx_wp <= r_tx_wp + c_TX_AW'(1);
            if (w_tx_pop)
                r_tx_rp <= r_tx_rp + c_TX_AW'(1);
            if (w_tx_push && !w_tx_pop)
                r_tx_cnt <= r_tx_cnt + (c_TX_AW + 1)'(1);
            else if (!w_tx_push && w_tx_pop)
                r_tx_cnt <= r_tx_cnt - (c_TX_AW + 1)'(1);

            if (w_rx_push)
                r_rx_wp <= r_rx_wp + c_RX_AW'(1);
            if (w_rx_pop)
                r_rx_rp <= r_rx_rp + c_RX_AW'(1);
            if (w_rx_push && !w_rx_pop)
                r_rx_cnt <= r_rx_cnt + (c_RX_AW + 1)'(1);
            else if (!w_rx_push && w_rx_pop)
                r_rx_cnt <= r_rx_cnt - (c_RX_AW + 1)'(1);
        end
    end

`ifdef ADDR_TRAP_EN
    logic r_addr_err;
    always_ff @(posedge clk_in) begin
        if (rst_in)
            r_addr_err <= 1'b0;
        else if (w_is_oor)
            r_addr_err <= 1'b1;
    end
    assign addr_err = r_addr_err;
`else
    assign addr_err = 1'b0;
`endif

endmodule
`default_nettype wire
